// File: rtl/hash_arbiter.sv
// Round-robin arbiter that shares one hash core between NUM_REQ requesters.
// A granted owner keeps the core until it forces done and the core acknowledges.
module hash_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int IO_WIDTH = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_start,
  input  logic [NUM_REQ*32-1:0]        i_req_input_length,
  input  logic [NUM_REQ*32-1:0]        i_req_output_length,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  i_req_data_in,
  output logic [ADDR_W-1:0]            o_req_addr,
  output logic [NUM_REQ-1:0]           o_req_rd_en,
  output logic [IO_WIDTH-1:0]          o_req_data_out,
  output logic [NUM_REQ-1:0]           o_req_data_out_valid,
  input  logic [NUM_REQ-1:0]           i_req_data_out_ready,
  input  logic [NUM_REQ-1:0]           i_req_force_done,
  output logic [NUM_REQ-1:0]           o_req_force_done_ack,
  output logic                         o_hash_start,
  output logic [31:0]                  o_hash_input_length,
  output logic [31:0]                  o_hash_output_length,
  output logic [IO_WIDTH-1:0]          o_hash_data_in,
  input  logic [ADDR_W-1:0]            i_hash_addr,
  input  logic                         i_hash_rd_en,
  input  logic [IO_WIDTH-1:0]          i_hash_data_out,
  input  logic                         i_hash_data_out_valid,
  output logic                         o_hash_data_out_ready,
  output logic                         o_hash_force_done,
  input  logic                         i_hash_force_done_ack,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d, grant_q, grant_d, clr;
  logic [IW-1:0]      ptr_q, ptr_d, own_q, own_d, pick;
  logic [31:0]        ilen_q, ilen_d, olen_q, olen_d;
  logic               found;
  int unsigned        idx;

  // First pending requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      ilen_q  <= '0;
      olen_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      ilen_q  <= ilen_d;
      olen_q  <= olen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    ilen_d  = ilen_q;
    olen_d  = olen_q;
    clr     = '0;
    unique case (state_q)
      IDLE: if (found) begin
        clr[pick]    = 1'b1;
        grant_d      = '0;
        grant_d[pick] = 1'b1;
        own_d        = pick;
        ilen_d       = i_req_input_length[pick*32 +: 32];
        olen_d       = i_req_output_length[pick*32 +: 32];
        state_d      = LAUNCH;
      end
      LAUNCH: state_d = BUSY;
      BUSY: if (i_req_force_done[own_q]) state_d = RELEASE;
      RELEASE: if (i_hash_force_done_ack) begin
        ptr_d   = (int'(own_q) == NUM_REQ - 1) ? '0 : own_q + 1'b1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A pulse from a requester that is already pending is simply absorbed.
    pend_d = (pend_q | i_req_start) & ~clr;
  end

  assign o_req_addr           = i_hash_addr;
  assign o_req_data_out       = i_hash_data_out;
  assign o_grant              = grant_q;
  assign o_busy               = (state_q != IDLE);
  assign o_hash_input_length  = ilen_q;
  assign o_hash_output_length = olen_q;

  always_comb begin
    o_hash_start          = 1'b0;
    o_hash_data_in        = '0;
    o_hash_data_out_ready = 1'b0;
    o_hash_force_done     = 1'b0;
    o_req_rd_en           = '0;
    o_req_data_out_valid  = '0;
    o_req_force_done_ack  = '0;
    unique case (state_q)
      LAUNCH: o_hash_start = 1'b1;
      BUSY: begin
        o_hash_data_in              = i_req_data_in[own_q*IO_WIDTH +: IO_WIDTH];
        o_hash_data_out_ready       = i_req_data_out_ready[own_q];
        o_hash_force_done           = i_req_force_done[own_q];
        o_req_rd_en[own_q]          = i_hash_rd_en;
        o_req_data_out_valid[own_q] = i_hash_data_out_valid;
      end
      RELEASE: begin
        o_hash_data_out_ready       = i_req_data_out_ready[own_q];
        o_hash_force_done           = 1'b1;
        o_req_force_done_ack[own_q] = i_hash_force_done_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// Bench for hash_arbiter: directed literal checks, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_hash_arbiter;
  localparam int N  = 2;
  localparam int IO = 32;
  localparam int AW = 4;

  logic              i_clk = 1'b0, i_rst = 1'b1;
  logic [N-1:0]      i_req_start = '0;
  logic [N*32-1:0]   i_req_input_length = '0, i_req_output_length = '0;
  logic [N*IO-1:0]   i_req_data_in = '0;
  logic [AW-1:0]     o_req_addr;
  logic [N-1:0]      o_req_rd_en, o_req_data_out_valid, o_req_force_done_ack, o_grant;
  logic [IO-1:0]     o_req_data_out, o_hash_data_in;
  logic [N-1:0]      i_req_data_out_ready = '0, i_req_force_done = '0;
  logic              o_hash_start, o_hash_data_out_ready, o_hash_force_done, o_busy;
  logic [31:0]       o_hash_input_length, o_hash_output_length;
  logic [AW-1:0]     i_hash_addr = '0;
  logic              i_hash_rd_en = 1'b0, i_hash_data_out_valid = 1'b0, i_hash_force_done_ack = 1'b0;
  logic [IO-1:0]     i_hash_data_out = '0;

  hash_arbiter #(.NUM_REQ(N), .IO_WIDTH(IO), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_start(i_req_start),
    .i_req_input_length(i_req_input_length), .i_req_output_length(i_req_output_length),
    .i_req_data_in(i_req_data_in), .o_req_addr(o_req_addr), .o_req_rd_en(o_req_rd_en),
    .o_req_data_out(o_req_data_out), .o_req_data_out_valid(o_req_data_out_valid),
    .i_req_data_out_ready(i_req_data_out_ready), .i_req_force_done(i_req_force_done),
    .o_req_force_done_ack(o_req_force_done_ack), .o_hash_start(o_hash_start),
    .o_hash_input_length(o_hash_input_length), .o_hash_output_length(o_hash_output_length),
    .o_hash_data_in(o_hash_data_in), .i_hash_addr(i_hash_addr), .i_hash_rd_en(i_hash_rd_en),
    .i_hash_data_out(i_hash_data_out), .i_hash_data_out_valid(i_hash_data_out_valid),
    .o_hash_data_out_ready(o_hash_data_out_ready), .o_hash_force_done(o_hash_force_done),
    .i_hash_force_done_ack(i_hash_force_done_ack), .o_grant(o_grant), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  // Model: which requester holds the core (-1 none) and which phase of its
  // transaction it is in (0 idle, 1 start pulse, 2 streaming, 3 awaiting ack).
  int          m_owner = -1, m_phase = 0, m_ptr = 0;
  bit [N-1:0]  m_pend = '0;
  logic [31:0] m_ilen = '0, m_olen = '0;
  int          grants[$];

  always @(negedge i_clk) begin
    logic [N-1:0] e_rd, e_vld, e_ack, e_gnt;
    logic [IO-1:0] e_din;
    logic e_rdy, e_fd;
    e_gnt = '0; e_rd = '0; e_vld = '0; e_ack = '0; e_din = '0; e_rdy = 1'b0; e_fd = 1'b0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    if (m_phase == 2) begin
      e_din = i_req_data_in[m_owner*IO +: IO];
      e_rd[m_owner]  = i_hash_rd_en;
      e_vld[m_owner] = i_hash_data_out_valid;
      e_fd  = i_req_force_done[m_owner];
    end
    if (m_phase == 2 || m_phase == 3) e_rdy = i_req_data_out_ready[m_owner];
    if (m_phase == 3) begin
      e_fd = 1'b1;
      e_ack[m_owner] = i_hash_force_done_ack;
    end
    chk("grant", o_grant, e_gnt);
    chk("busy", o_busy, m_phase != 0);
    chk("hash_start", o_hash_start, m_phase == 1);
    chk("in_len", o_hash_input_length, m_ilen);
    chk("out_len", o_hash_output_length, m_olen);
    chk("data_in", o_hash_data_in, e_din);
    chk("ready", o_hash_data_out_ready, e_rdy);
    chk("force_done", o_hash_force_done, e_fd);
    chk("rd_en", o_req_rd_en, e_rd);
    chk("valid", o_req_data_out_valid, e_vld);
    chk("ack", o_req_force_done_ack, e_ack);
    chk("addr", o_req_addr, i_hash_addr);
    chk("data_out", o_req_data_out, i_hash_data_out);

    // Advance the model with the inputs the DUT samples at the next edge.
    if (i_rst) begin
      m_owner = -1; m_phase = 0; m_ptr = 0; m_pend = '0; m_ilen = '0; m_olen = '0;
    end else begin
      bit [N-1:0] np;
      int g;
      np = m_pend | i_req_start;
      g = -1;
      case (m_phase)
        0: for (int k = 0; k < N; k++)
             if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        1: m_phase = 2;
        2: if (i_req_force_done[m_owner]) m_phase = 3;
        3: if (i_hash_force_done_ack) begin
             m_ptr = (m_owner + 1) % N; m_owner = -1; m_phase = 0;
           end
        default: ;
      endcase
      if (g >= 0) begin
        np[g] = 1'b0; m_owner = g; m_phase = 1;
        m_ilen = i_req_input_length[g*32 +: 32];
        m_olen = i_req_output_length[g*32 +: 32];
        grants.push_back(g);
      end
      m_pend = np;
    end
  end

  initial begin
    repeat (3) cyc();
    i_rst = 1'b0;
    cyc();
    @(negedge i_clk);
    chk("lit_rst_busy", o_busy, 0);
    chk("lit_rst_grant", o_grant, 0);
    chk("lit_rst_fd", o_hash_force_done, 0);

    // Single request: start at t, lengths 256/128, launch at t+2.
    cyc();
    i_req_start = 2'b01; i_req_input_length[31:0] = 256; i_req_output_length[31:0] = 128;
    cyc();
    i_req_start = '0;
    @(negedge i_clk);
    chk("lit_t1_start", o_hash_start, 0);
    cyc();
    @(negedge i_clk);
    chk("lit_t2_start", o_hash_start, 1);
    chk("lit_t2_ilen", o_hash_input_length, 256);
    chk("lit_t2_olen", o_hash_output_length, 128);
    chk("lit_t2_grant", o_grant, 2'b01);
    cyc();
    i_hash_rd_en = 1'b1; i_hash_data_out_valid = 1'b1;
    @(negedge i_clk);
    chk("lit_rd_en", o_req_rd_en, 2'b01);
    chk("lit_valid", o_req_data_out_valid, 2'b01);
    chk("lit_ready_low", o_hash_data_out_ready, 0);

    // Release with a 3-cycle ack delay.
    cyc();
    i_hash_rd_en = 1'b0; i_hash_data_out_valid = 1'b0; i_req_force_done = 2'b01;
    @(negedge i_clk);
    chk("lit_fd_busy", o_hash_force_done, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      i_req_force_done = '0;
      @(negedge i_clk);
      chk("lit_fd_hold", o_hash_force_done, 1);
      chk("lit_no_ack", o_req_force_done_ack, 0);
    end
    cyc();
    i_hash_force_done_ack = 1'b1;
    @(negedge i_clk);
    chk("lit_ack_owner", o_req_force_done_ack, 2'b01);
    cyc();
    i_hash_force_done_ack = 1'b0;
    @(negedge i_clk);
    chk("lit_idle_after", o_busy, 0);

    // Simultaneous starts after the pointer moved to 1: req1 goes first.
    grants.delete();
    cyc();
    i_req_start = 2'b11;
    cyc();
    i_req_start = '0;
    repeat (3) cyc();
    i_req_force_done = 2'b11; i_hash_force_done_ack = 1'b1;
    repeat (8) cyc();
    i_req_force_done = '0; i_hash_force_done_ack = 1'b0;
    cyc();
    @(negedge i_clk);
    chk("lit_rr_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("lit_rr_first", grants[0], 1);
      chk("lit_rr_second", grants[1], 0);
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      i_rst = ($urandom_range(0, 299) == 0);
      for (int r = 0; r < N; r++) begin
        i_req_start[r]          = ($urandom_range(0, 7) == 0);
        i_req_force_done[r]     = ($urandom_range(0, 5) == 0);
        i_req_data_out_ready[r] = $urandom_range(0, 1);
        i_req_input_length[r*32 +: 32]  = $urandom;
        i_req_output_length[r*32 +: 32] = $urandom;
        i_req_data_in[r*IO +: IO]       = $urandom;
      end
      i_hash_addr = AW'($urandom);
      i_hash_rd_en = $urandom_range(0, 1);
      i_hash_data_out = $urandom;
      i_hash_data_out_valid = $urandom_range(0, 1);
      i_hash_force_done_ack = ($urandom_range(0, 2) == 0);
    end
    cyc();
    @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
